// File: rtl/cpu_step_ctrl_if.sv
// Board-side signals of the execution-enable controller.
// The DUT takes the slave modport; the driver of switches/slow clock takes master.
interface cpu_step_ctrl_if;
  logic        slow_clk;
  logic        run_sw;
  logic        step_btn;
  logic        halt_req;
  logic        cpu_en;
  logic [15:0] step_count;
  logic [1:0]  state;

  modport master (
    output slow_clk,
    output run_sw,
    output step_btn,
    output halt_req,
    input  cpu_en,
    input  step_count,
    input  state
  );

  modport slave (
    input  slow_clk,
    input  run_sw,
    input  step_btn,
    input  halt_req,
    output cpu_en,
    output step_count,
    output state
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Turns slow_clk rising edges into single-cycle cpu_en pulses (free-run, debounced step, core halt).
// Latency: slow_clk rise sampled at edge N -> cpu_en high N+2..N+3; no backpressure, presses in RUN/ARM are dropped.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic           clk_,
  input  logic           rst_n,
  cpu_step_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    ARM  = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             slow_meta_q, slow_meta_d;
  logic             slow_s_q,    slow_s_d;
  logic             slow_d_q,    slow_d_d;
  logic             run_meta_q,  run_meta_d;
  logic             run_s_q,     run_s_d;
  logic             btn_meta_q,  btn_meta_d;
  logic             btn_s_q,     btn_s_d;
  logic             btn_db_q,    btn_db_d;
  logic             btn_db_dly_q, btn_db_dly_d;
  logic [CNT_W-1:0] db_cnt_q,    db_cnt_d;
  state_e           state_q,     state_d;
  logic             cpu_en_q,    cpu_en_d;
  logic [15:0]      step_count_q, step_count_d;

  logic tick;
  logic btn_press;

  // Two-flop synchronisers plus the previous-value flop for slow-clock edge detection.
  always_comb begin
    slow_meta_d = bus.slow_clk;
    slow_s_d    = slow_meta_q;
    slow_d_d    = slow_s_q;
    run_meta_d  = bus.run_sw;
    run_s_d     = run_meta_q;
    btn_meta_d  = bus.step_btn;
    btn_s_d     = btn_meta_q;
  end

  assign tick      = slow_s_q & ~slow_d_q;
  assign btn_press = btn_db_q & ~btn_db_dly_q;

  // The accepted level flips only after btn_s has disagreed with it for DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    btn_db_d     = btn_db_q;
    db_cnt_d     = '0;
    btn_db_dly_d = btn_db_q;
    if (btn_s_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = btn_s_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    unique case (state_q)
      HALT: begin
        if (bus.halt_req) begin
          state_d = HALT;
        end else if (run_s_q) begin
          state_d = RUN;
        end else if (btn_press) begin
          state_d = ARM;
        end
      end
      RUN: begin
        if (bus.halt_req || !run_s_q) begin
          state_d = HALT;
        end else if (tick) begin
          cpu_en_d = 1'b1;
        end
      end
      ARM: begin
        if (bus.halt_req) begin
          state_d = HALT;
        end else if (tick) begin
          cpu_en_d = 1'b1;
          state_d  = HALT;
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  always_comb begin
    step_count_d = step_count_q + {15'd0, cpu_en_q};
  end

  always_ff @(posedge clk_ or negedge rst_n) begin
    if (!rst_n) begin
      slow_meta_q  <= 1'b0;
      slow_s_q     <= 1'b0;
      slow_d_q     <= 1'b0;
      run_meta_q   <= 1'b0;
      run_s_q      <= 1'b0;
      btn_meta_q   <= 1'b0;
      btn_s_q      <= 1'b0;
      btn_db_q     <= 1'b0;
      btn_db_dly_q <= 1'b0;
      db_cnt_q     <= '0;
      state_q      <= HALT;
      cpu_en_q     <= 1'b0;
      step_count_q <= 16'd0;
    end else begin
      slow_meta_q  <= slow_meta_d;
      slow_s_q     <= slow_s_d;
      slow_d_q     <= slow_d_d;
      run_meta_q   <= run_meta_d;
      run_s_q      <= run_s_d;
      btn_meta_q   <= btn_meta_d;
      btn_s_q      <= btn_s_d;
      btn_db_q     <= btn_db_d;
      btn_db_dly_q <= btn_db_dly_d;
      db_cnt_q     <= db_cnt_d;
      state_q      <= state_d;
      cpu_en_q     <= cpu_en_d;
      step_count_q <= step_count_d;
    end
  end

  assign bus.cpu_en     = cpu_en_q;
  assign bus.step_count = step_count_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with a cycle-level reference model and literal spot checks.
module tb_cpu_step_ctrl;

  localparam int DB = 4;
  localparam int M_HALT = 0;
  localparam int M_RUN  = 1;
  localparam int M_ARM  = 2;

  logic clk_  = 1'b0;
  logic rst_n = 1'b0;

  cpu_step_ctrl_if bus ();

  cpu_step_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(20)) dut (
    .clk_ (clk_),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk_ = ~clk_;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: inputs as seen 1/2/3 edges ago, debounced level, mode, pulse, count.
  bit       h_slow [3];
  bit       h_run  [3];
  bit       h_btn  [3];
  bit       m_db, m_db_prev;
  int       m_streak;
  int       m_mode;
  bit       m_en;
  bit [15:0] m_cnt;

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      h_slow[i] = 0; h_run[i] = 0; h_btn[i] = 0;
    end
    m_db = 0; m_db_prev = 0; m_streak = 0;
    m_mode = M_HALT; m_en = 0; m_cnt = 16'd0;
  endtask

  task automatic m_step();
    bit tk, rs, bs, pr, hr, nen;
    int nmode;
    tk = h_slow[1] && !h_slow[2];
    rs = h_run[1];
    bs = h_btn[1];
    pr = m_db && !m_db_prev;
    hr = bus.halt_req;
    nen   = tk && !hr && ((m_mode == M_RUN && rs) || m_mode == M_ARM);
    nmode = m_mode;
    if (m_mode == M_HALT) nmode = hr ? M_HALT : rs ? M_RUN : pr ? M_ARM : M_HALT;
    else if (m_mode == M_RUN) nmode = (hr || !rs) ? M_HALT : M_RUN;
    else nmode = (hr || tk) ? M_HALT : M_ARM;
    m_cnt = m_cnt + (m_en ? 16'd1 : 16'd0);
    m_en  = nen;
    m_mode = nmode;
    m_db_prev = m_db;
    if (bs != m_db) begin
      m_streak++;
      if (m_streak == DB) begin
        m_db = bs;
        m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
    h_slow[2] = h_slow[1]; h_slow[1] = h_slow[0]; h_slow[0] = bus.slow_clk;
    h_run[2]  = h_run[1];  h_run[1]  = h_run[0];  h_run[0]  = bus.run_sw;
    h_btn[2]  = h_btn[1];  h_btn[1]  = h_btn[0];  h_btn[0]  = bus.step_btn;
  endtask

  always @(posedge clk_ or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  always @(posedge clk_) begin
    #1;
    if (rst_n) begin
      chk("model_cpu_en", {31'd0, bus.cpu_en}, {31'd0, m_en});
      chk("model_state", {30'd0, bus.state}, m_mode);
      chk("model_step_count", {16'd0, bus.step_count}, {16'd0, m_cnt});
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk_);
  endtask

  task automatic slow_cycle(input int hi, input int lo);
    @(negedge clk_);
    bus.slow_clk = 1'b1;
    wait_neg(hi);
    bus.slow_clk = 1'b0;
    wait_neg(lo - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit seen;
    bus.slow_clk = 1'b0;
    bus.run_sw   = 1'b1;
    bus.step_btn = 1'b0;
    bus.halt_req = 1'b0;
    m_reset();

    // Reset state
    wait_neg(3);
    #1;
    chk("reset_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
    chk("reset_state", {30'd0, bus.state}, 32'd0);
    chk("reset_step_count", {16'd0, bus.step_count}, 32'd0);
    @(negedge clk_);
    rst_n = 1'b1;

    // RUN appears on the third edge after release
    @(posedge clk_); @(posedge clk_); #1;
    chk("halt_before_run", {30'd0, bus.state}, 32'd0);
    @(posedge clk_); #1;
    chk("run_after_3_edges", {30'd0, bus.state}, 32'd1);

    // First pulse: exact latency and width
    @(negedge clk_);
    bus.slow_clk = 1'b1;
    @(posedge clk_); #1; chk("lat_edge_n", {31'd0, bus.cpu_en}, 32'd0);
    @(posedge clk_); #1; chk("lat_edge_n1", {31'd0, bus.cpu_en}, 32'd0);
    @(posedge clk_); #1; chk("lat_edge_n2", {31'd0, bus.cpu_en}, 32'd1);
    @(posedge clk_); #1; chk("lat_edge_n3", {31'd0, bus.cpu_en}, 32'd0);
    chk("count_after_first", {16'd0, bus.step_count}, 32'd1);
    wait_neg(6);
    bus.slow_clk = 1'b0;
    wait_neg(10);
    for (int i = 0; i < 4; i++) slow_cycle(10, 10);
    chk("count_free_run_5", {16'd0, bus.step_count}, 32'd5);

    // Halt from core coincident with tick
    @(negedge clk_);
    bus.slow_clk = 1'b1;
    @(posedge clk_); @(posedge clk_);
    @(negedge clk_);
    bus.halt_req = 1'b1;
    @(posedge clk_); #1;
    chk("halt_no_pulse", {31'd0, bus.cpu_en}, 32'd0);
    chk("halt_state", {30'd0, bus.state}, 32'd0);
    @(negedge clk_);
    bus.halt_req = 1'b0;
    @(posedge clk_); #1;
    chk("resume_run", {30'd0, bus.state}, 32'd1);
    chk("halt_count_kept", {16'd0, bus.step_count}, 32'd5);
    wait_neg(8);
    bus.slow_clk = 1'b0;
    wait_neg(10);

    // Single step with a bouncing button
    bus.run_sw = 1'b0;
    wait_neg(4);
    chk("step_mode_halt", {30'd0, bus.state}, 32'd0);
    bus.step_btn = 1'b1;
    @(negedge clk_); bus.step_btn = 1'b0;
    @(negedge clk_); bus.step_btn = 1'b1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk_); #1;
      if (bus.state == 2'b10) seen = 1;
    end
    chk("armed_after_press", {31'd0, seen}, 32'd1);
    chk("armed_no_pulse", {16'd0, bus.step_count}, 32'd5);
    @(negedge clk_);
    bus.step_btn = 1'b0;
    wait_neg(10);
    bus.step_btn = 1'b1;
    wait_neg(10);
    chk("second_press_dropped", {30'd0, bus.state}, 32'd2);
    slow_cycle(10, 10);
    chk("step_back_to_halt", {30'd0, bus.state}, 32'd0);
    chk("step_count_plus1", {16'd0, bus.step_count}, 32'd6);
    wait_neg(10);
    chk("no_queued_press", {30'd0, bus.state}, 32'd0);
    bus.step_btn = 1'b0;
    wait_neg(10);

    // Glitch shorter than the debounce window
    bus.step_btn = 1'b1;
    wait_neg(3);
    bus.step_btn = 1'b0;
    wait_neg(15);
    chk("glitch_state", {30'd0, bus.state}, 32'd0);
    chk("glitch_count", {16'd0, bus.step_count}, 32'd6);

    // Wrap-around of step_count, preloaded near the top
    bus.run_sw = 1'b1;
    wait_neg(4);
    force dut.step_count_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1;
    release dut.step_count_q;
    slow_cycle(4, 4);
    chk("wrap_ffff", {16'd0, bus.step_count}, 32'h0000FFFF);
    slow_cycle(4, 4);
    chk("wrap_0000", {16'd0, bus.step_count}, 32'h00000000);
    slow_cycle(4, 4);
    chk("wrap_0001", {16'd0, bus.step_count}, 32'h00000001);
    wait_neg(4);

    // Reset while cpu_en is high
    @(negedge clk_);
    bus.slow_clk = 1'b1;
    @(posedge clk_); @(posedge clk_); @(posedge clk_); #1;
    chk("pre_reset_pulse", {31'd0, bus.cpu_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
    chk("midrst_state", {30'd0, bus.state}, 32'd0);
    chk("midrst_count", {16'd0, bus.step_count}, 32'd0);
    @(negedge clk_);
    rst_n = 1'b1;
    wait_neg(12);
    chk("post_rst_no_pulse", {16'd0, bus.step_count}, 32'd0);
    chk("post_rst_run", {30'd0, bus.state}, 32'd1);
    bus.slow_clk = 1'b0;
    wait_neg(5);
    bus.slow_clk = 1'b1;
    wait_neg(6);
    chk("post_rst_next_edge", {16'd0, bus.step_count}, 32'd1);
    bus.slow_clk = 1'b0;
    wait_neg(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
